// File: rtl/rams_pkg.sv
// Shared definitions for the single-port 64x20 RAM and its two-client arbiter.
package rams_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 20;

    localparam int P_FETCH = 0;
    localparam int P_CFG   = 1;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_CFG   = 1'b1
    } port_e;

    typedef struct packed {
        logic                  we;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] di;
    } ram_req_t;

endpackage

// File: rtl/rams_sp_arb2_if.sv
// Client request/response and RAM port bundle for rams_sp_arb2.
interface rams_sp_arb2_if #(
    parameter int ADDR_W = rams_pkg::RAM_ADDR_W,
    parameter int DATA_W = rams_pkg::RAM_DATA_W
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] di0, di1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, di0, di1, ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_we, ram_addr, ram_di
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, di0, di1, ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_we, ram_addr, ram_di
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin (RR != 0) or fixed priority to port 0.
module rr_arb2
    import rams_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    port_e r_last_gnt;

    always_comb begin
        o_gnt = '0;
        if (rst_n) begin
            unique case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11: begin
                    if (RR != 0)
                        o_gnt = (r_last_gnt == PORT_CFG) ? 2'b01 : 2'b10;
                    else
                        o_gnt = 2'b01;
                end
                default: o_gnt = '0;
            endcase
        end
    end

    // Reset to "port 1 last" so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_last_gnt <= PORT_CFG;
        else if (|o_gnt)
            r_last_gnt <= o_gnt[P_CFG] ? PORT_CFG : PORT_FETCH;
    end
endmodule

// File: rtl/rams_sp_arb2.sv
// Shares one registered single-port RAM between fetch (port 0) and config (port 1).
module rams_sp_arb2
    import rams_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int RR     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    rams_sp_arb2_if.slave bus
);
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_di;
    logic              r_rvalid0;
    logic              r_rvalid1;

    assign w_req = {bus.req1, bus.req0};

    rr_arb2 #(.RR(RR)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_we   = 1'b0;
        w_addr = bus.addr0;
        w_di   = bus.di0;
        if (!rst_n) begin
            w_addr = '0;
            w_di   = '0;
        end else if (w_gnt[P_CFG]) begin
            w_we   = bus.we1;
            w_addr = bus.addr1;
            w_di   = bus.di1;
        end else if (w_gnt[P_FETCH]) begin
            w_we   = bus.we0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt[P_FETCH] & ~bus.we0;
            r_rvalid1 <= w_gnt[P_CFG]   & ~bus.we1;
        end
    end

    assign bus.gnt0     = w_gnt[P_FETCH];
    assign bus.gnt1     = w_gnt[P_CFG];
    assign bus.ram_we   = w_we;
    assign bus.ram_addr = w_addr;
    assign bus.ram_di   = w_di;
    // Gating with rst_n drops a read whose data would land in a reset cycle.
    assign bus.rvalid0  = r_rvalid0 & rst_n;
    assign bus.rvalid1  = r_rvalid1 & rst_n;
    assign bus.rdata0   = bus.ram_dout;
    assign bus.rdata1   = bus.ram_dout;
endmodule

// File: tb/tb_rams_sp_arb2.sv
// Bench: two arbiters (index 0 fixed priority, index 1 round-robin), each with its own RAM model.
module tb_rams_sp_arb2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        req0_s [2];
    logic        req1_s [2];
    logic        we0_s  [2];
    logic        we1_s  [2];
    logic [5:0]  addr0_s[2];
    logic [5:0]  addr1_s[2];
    logic [19:0] di0_s  [2];
    logic [19:0] di1_s  [2];

    logic        gnt0_w  [2];
    logic        gnt1_w  [2];
    logic        rv0_w   [2];
    logic        rv1_w   [2];
    logic [19:0] rd0_w   [2];
    logic [19:0] rd1_w   [2];
    logic        rwe_w   [2];
    logic [5:0]  raddr_w [2];
    logic [19:0] rdi_w   [2];

    rams_sp_arb2_if #(.ADDR_W(6), .DATA_W(20)) bus_fp ();
    rams_sp_arb2_if #(.ADDR_W(6), .DATA_W(20)) bus_rr ();

    rams_sp_arb2 #(.ADDR_W(6), .DATA_W(20), .RR(0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));
    rams_sp_arb2 #(.ADDR_W(6), .DATA_W(20), .RR(1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));

    assign bus_fp.req0 = req0_s[0];  assign bus_rr.req0 = req0_s[1];
    assign bus_fp.req1 = req1_s[0];  assign bus_rr.req1 = req1_s[1];
    assign bus_fp.we0  = we0_s[0];   assign bus_rr.we0  = we0_s[1];
    assign bus_fp.we1  = we1_s[0];   assign bus_rr.we1  = we1_s[1];
    assign bus_fp.addr0 = addr0_s[0]; assign bus_rr.addr0 = addr0_s[1];
    assign bus_fp.addr1 = addr1_s[0]; assign bus_rr.addr1 = addr1_s[1];
    assign bus_fp.di0  = di0_s[0];   assign bus_rr.di0  = di0_s[1];
    assign bus_fp.di1  = di1_s[0];   assign bus_rr.di1  = di1_s[1];

    assign gnt0_w[0] = bus_fp.gnt0;     assign gnt0_w[1] = bus_rr.gnt0;
    assign gnt1_w[0] = bus_fp.gnt1;     assign gnt1_w[1] = bus_rr.gnt1;
    assign rv0_w[0]  = bus_fp.rvalid0;  assign rv0_w[1]  = bus_rr.rvalid0;
    assign rv1_w[0]  = bus_fp.rvalid1;  assign rv1_w[1]  = bus_rr.rvalid1;
    assign rd0_w[0]  = bus_fp.rdata0;   assign rd0_w[1]  = bus_rr.rdata0;
    assign rd1_w[0]  = bus_fp.rdata1;   assign rd1_w[1]  = bus_rr.rdata1;
    assign rwe_w[0]  = bus_fp.ram_we;   assign rwe_w[1]  = bus_rr.ram_we;
    assign raddr_w[0] = bus_fp.ram_addr; assign raddr_w[1] = bus_rr.ram_addr;
    assign rdi_w[0]  = bus_fp.ram_di;   assign rdi_w[1]  = bus_rr.ram_di;

    // RAM models: registered read, read-first, with a preload path.
    logic        init_en = 1'b1;
    logic [5:0]  init_a  = '0;
    logic [19:0] init_d  = '0;
    logic [19:0] mem0 [64];
    logic [19:0] mem1 [64];
    logic [19:0] dout0, dout1;

    always @(posedge clk) begin
        if (init_en) mem0[init_a] <= init_d;
        else if (bus_fp.ram_we) mem0[bus_fp.ram_addr] <= bus_fp.ram_di;
        dout0 <= mem0[bus_fp.ram_addr];
    end
    always @(posedge clk) begin
        if (init_en) mem1[init_a] <= init_d;
        else if (bus_rr.ram_we) mem1[bus_rr.ram_addr] <= bus_rr.ram_di;
        dout1 <= mem1[bus_rr.ram_addr];
    end
    assign bus_fp.ram_dout = dout0;
    assign bus_rr.ram_dout = dout1;

    // Reference model state, per instance.
    logic [19:0] ref_mem [2][64];
    int          last_m [2];
    int          g_m    [2];
    bit          pend_v [2];
    int          pend_p [2];
    logic [19:0] pend_d [2];

    function automatic int model_grant(int i);
        if (!rst_n) return -1;
        if (req0_s[i] && req1_s[i]) return (i == 1) ? 1 - last_m[i] : 0;
        if (req0_s[i]) return 0;
        if (req1_s[i]) return 1;
        return -1;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            req0_s[i] = 1'b0; req1_s[i] = 1'b0;
            we0_s[i]  = 1'b0; we1_s[i]  = 1'b0;
        end
    endtask

    // One clock: compare every DUT output against the model, then advance the model.
    task automatic cycle();
        int g;
        logic        e_we, e_rv0, e_rv1;
        logic [5:0]  e_addr;
        logic [19:0] e_di;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            g = model_grant(i);
            n_checks++;
            if (gnt0_w[i] !== (g == 0)) begin
                n_fail++; $display("FAIL gnt0[%0d] t=%0t got %b exp %b", i, $time, gnt0_w[i], g == 0);
            end
            n_checks++;
            if (gnt1_w[i] !== (g == 1)) begin
                n_fail++; $display("FAIL gnt1[%0d] t=%0t got %b exp %b", i, $time, gnt1_w[i], g == 1);
            end
            e_we = (g == 0) ? we0_s[i] : (g == 1) ? we1_s[i] : 1'b0;
            n_checks++;
            if (rwe_w[i] !== e_we) begin
                n_fail++; $display("FAIL ram_we[%0d] t=%0t got %b exp %b", i, $time, rwe_w[i], e_we);
            end
            if (!rst_n || g >= 0) begin
                e_addr = !rst_n ? 6'd0 : (g == 0) ? addr0_s[i] : addr1_s[i];
                e_di   = !rst_n ? 20'd0 : (g == 0) ? di0_s[i] : di1_s[i];
                n_checks++;
                if (raddr_w[i] !== e_addr) begin
                    n_fail++; $display("FAIL ram_addr[%0d] t=%0t got %h exp %h", i, $time, raddr_w[i], e_addr);
                end
                n_checks++;
                if (rdi_w[i] !== e_di) begin
                    n_fail++; $display("FAIL ram_di[%0d] t=%0t got %h exp %h", i, $time, rdi_w[i], e_di);
                end
            end
            e_rv0 = rst_n && pend_v[i] && pend_p[i] == 0;
            e_rv1 = rst_n && pend_v[i] && pend_p[i] == 1;
            n_checks++;
            if (rv0_w[i] !== e_rv0) begin
                n_fail++; $display("FAIL rvalid0[%0d] t=%0t got %b exp %b", i, $time, rv0_w[i], e_rv0);
            end
            n_checks++;
            if (rv1_w[i] !== e_rv1) begin
                n_fail++; $display("FAIL rvalid1[%0d] t=%0t got %b exp %b", i, $time, rv1_w[i], e_rv1);
            end
            if (e_rv0) begin
                n_checks++;
                if (rd0_w[i] !== pend_d[i]) begin
                    n_fail++; $display("FAIL rdata0[%0d] t=%0t got %h exp %h", i, $time, rd0_w[i], pend_d[i]);
                end
            end
            if (e_rv1) begin
                n_checks++;
                if (rd1_w[i] !== pend_d[i]) begin
                    n_fail++; $display("FAIL rdata1[%0d] t=%0t got %h exp %h", i, $time, rd1_w[i], pend_d[i]);
                end
            end
            pend_v[i] = 1'b0;
            if (!rst_n) begin
                last_m[i] = 1;
            end else if (g >= 0) begin
                last_m[i] = g;
                e_we   = (g == 0) ? we0_s[i] : we1_s[i];
                e_addr = (g == 0) ? addr0_s[i] : addr1_s[i];
                e_di   = (g == 0) ? di0_s[i] : di1_s[i];
                if (e_we) begin
                    ref_mem[i][e_addr] = e_di;
                end else begin
                    pend_v[i] = 1'b1;
                    pend_p[i] = g;
                    pend_d[i] = ref_mem[i][e_addr];
                end
            end
            g_m[i] = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) begin
                req0_s[i] = 1'b1; req1_s[i] = 1'($urandom);
                we0_s[i] = 1'($urandom); we1_s[i] = 1'($urandom);
                addr0_s[i] = 6'($urandom); addr1_s[i] = 6'($urandom);
                di0_s[i] = 20'($urandom);  di1_s[i] = 20'($urandom);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (gnt0_w[i] !== 1'b0 || rwe_w[i] !== 1'b0 || raddr_w[i] !== 6'd0) begin
                    n_fail++; $display("FAIL reset_force[%0d] got gnt0=%b we=%b addr=%h exp 0 0 00", i, gnt0_w[i], rwe_w[i], raddr_w[i]);
                end
            end
            cycle();
        end
        idle_all();
        rst_n = 1'b1;
        n_checks++;
        if (rv0_w[1] !== 1'b0 || rv1_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL reset_rvalid got %b%b exp 00", rv0_w[1], rv1_w[1]);
        end
        cycle();
    endtask

    task automatic test_single_read();
        idle_all();
        req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 6'd63;
        #1;
        n_checks++;
        if (gnt0_w[1] !== 1'b1) begin n_fail++; $display("FAIL single_gnt0 got %b exp 1", gnt0_w[1]); end
        cycle();
        req0_s[1] = 1'b0;
        n_checks++;
        if (rv0_w[1] !== 1'b1 || rd0_w[1] !== 20'h0200A || rv1_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL single_read got rv0=%b rd=%h rv1=%b exp 1 0200a 0", rv0_w[1], rd0_w[1], rv1_w[1]);
        end
        cycle();
    endtask

    task automatic test_rr_alternate();
        logic [19:0] e_d;
        rst_n = 1'b0; idle_all(); cycle(); rst_n = 1'b1;
        req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 6'd0;
        req1_s[1] = 1'b1; we1_s[1] = 1'b0; addr1_s[1] = 6'd1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (gnt0_w[1] !== (k % 2 == 0) || gnt1_w[1] !== (k % 2 == 1)) begin
                n_fail++; $display("FAIL rr_gnt k=%0d got %b%b exp %b%b", k, gnt1_w[1], gnt0_w[1], k % 2 == 1, k % 2 == 0);
            end
            if (k > 0) begin
                e_d = ((k - 1) % 2 == 0) ? 20'h0400D : 20'h08201;
                n_checks++;
                if (rv0_w[1] !== ((k - 1) % 2 == 0) || rv1_w[1] !== ((k - 1) % 2 == 1) || rd0_w[1] !== e_d) begin
                    n_fail++; $display("FAIL rr_rdata k=%0d got rv=%b%b rd=%h exp rd=%h", k, rv1_w[1], rv0_w[1], rd0_w[1], e_d);
                end
            end
            cycle();
        end
        idle_all();
        cycle();
    endtask

    task automatic test_fixed_prio();
        req0_s[0] = 1'b1; we0_s[0] = 1'b0; addr0_s[0] = 6'd0;
        req1_s[0] = 1'b1; we1_s[0] = 1'b0; addr1_s[0] = 6'd1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (gnt0_w[0] !== 1'b1 || gnt1_w[0] !== 1'b0) begin
                n_fail++; $display("FAIL fp_gnt k=%0d got %b%b exp 01", k, gnt1_w[0], gnt0_w[0]);
            end
            cycle();
        end
        req0_s[0] = 1'b0;
        #1;
        n_checks++;
        if (gnt1_w[0] !== 1'b1 || rd0_w[0] !== 20'h0400D) begin
            n_fail++; $display("FAIL fp_handover got gnt1=%b rd0=%h exp 1 0400d", gnt1_w[0], rd0_w[0]);
        end
        cycle();
        idle_all();
        n_checks++;
        if (rv1_w[0] !== 1'b1 || rd1_w[0] !== 20'h08201) begin
            n_fail++; $display("FAIL fp_rdata1 got %b %h exp 1 08201", rv1_w[0], rd1_w[0]);
        end
        cycle();
    endtask

    task automatic test_write_then_read();
        idle_all();
        req1_s[1] = 1'b1; we1_s[1] = 1'b1; addr1_s[1] = 6'd5; di1_s[1] = 20'hABCDE;
        #1;
        n_checks++;
        if (gnt1_w[1] !== 1'b1) begin n_fail++; $display("FAIL wr_gnt1 got %b exp 1", gnt1_w[1]); end
        cycle();
        req1_s[1] = 1'b0; we1_s[1] = 1'b0;
        req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 6'd5;
        #1;
        n_checks++;
        if (gnt0_w[1] !== 1'b1 || rv1_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL wr_then_rd got gnt0=%b rv1=%b exp 1 0", gnt0_w[1], rv1_w[1]);
        end
        cycle();
        idle_all();
        n_checks++;
        if (rv0_w[1] !== 1'b1 || rd0_w[1] !== 20'hABCDE || rv1_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL raw_data got rv0=%b rd=%h rv1=%b exp 1 abcde 0", rv0_w[1], rd0_w[1], rv1_w[1]);
        end
        cycle();
    endtask

    task automatic test_reset_mid_read();
        idle_all();
        req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 6'd63;
        cycle();
        req0_s[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rv0_w[1] !== 1'b0) begin n_fail++; $display("FAIL mid_read_rvalid got %b exp 0", rv0_w[1]); end
        cycle();
        rst_n = 1'b1;
        req0_s[1] = 1'b1; addr0_s[1] = 6'd0;
        req1_s[1] = 1'b1; we1_s[1] = 1'b0; addr1_s[1] = 6'd1;
        #1;
        n_checks++;
        if (gnt0_w[1] !== 1'b1 || rv0_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_gnt got gnt0=%b rv0=%b exp 1 0", gnt0_w[1], rv0_w[1]);
        end
        cycle();
        idle_all();
        cycle();
    endtask

    task automatic test_idle_last();
        idle_all();
        req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 6'd2;
        cycle();
        idle_all();
        for (int j = 0; j < 3; j++) begin
            #1;
            n_checks++;
            if (rwe_w[1] !== 1'b0 || (j > 0 && (rv0_w[1] !== 1'b0 || rv1_w[1] !== 1'b0))) begin
                n_fail++; $display("FAIL idle j=%0d got we=%b rv=%b%b exp 0 00", j, rwe_w[1], rv1_w[1], rv0_w[1]);
            end
            cycle();
        end
        req0_s[1] = 1'b1; addr0_s[1] = 6'd3;
        req1_s[1] = 1'b1; we1_s[1] = 1'b0; addr1_s[1] = 6'd4;
        #1;
        n_checks++;
        if (gnt1_w[1] !== 1'b1) begin n_fail++; $display("FAIL idle_last_gnt1 got %b exp 1", gnt1_w[1]); end
        cycle();
        idle_all();
        cycle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req0_s[i] || g_m[i] == 0) begin
                    req0_s[i] = ($urandom_range(0, 9) < 6);
                    we0_s[i] = ($urandom_range(0, 9) < 4);
                    addr0_s[i] = 6'($urandom); di0_s[i] = 20'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    req0_s[i] = 1'b0;
                end
                if (!req1_s[i] || g_m[i] == 1) begin
                    req1_s[i] = ($urandom_range(0, 9) < 6);
                    we1_s[i] = ($urandom_range(0, 9) < 4);
                    addr1_s[i] = 6'($urandom); di1_s[i] = 20'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    req1_s[i] = 1'b0;
                end
            end
            cycle();
        end
        idle_all();
        cycle();
    endtask

    initial begin
        logic [19:0] d;
        idle_all();
        for (int i = 0; i < 2; i++) begin
            addr0_s[i] = '0; addr1_s[i] = '0; di0_s[i] = '0; di1_s[i] = '0;
            last_m[i] = 1; g_m[i] = -1; pend_v[i] = 1'b0; pend_p[i] = 0; pend_d[i] = '0;
        end
        for (int a = 0; a < 64; a++) begin
            d = (a == 63) ? 20'h0200A : (a == 0) ? 20'h0400D : (a == 1) ? 20'h08201 : 20'($urandom);
            init_a = 6'(a); init_d = d;
            ref_mem[0][a] = d; ref_mem[1][a] = d;
            @(posedge clk); #1;
        end
        init_en = 1'b0;
        test_reset();
        test_single_read();
        test_rr_alternate();
        test_fixed_prio();
        test_write_then_read();
        test_reset_mid_read();
        test_idle_last();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
